clksw_req: RTL and testbench

CLKSW_REQ -- requirements
Module: clksw_req

---
 rtl/clksw_req.sv | 190 +++++++++++++++++++
 tb/tb_clksw_req.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clksw_req.sv
// clksw_req -- CPU clock-speed request controller.
//
// Decides when the CPU should ask the clock controller for the high-speed
// clock. A fast-space access while running on the low-speed clock raises a
// request and stalls the CPU until the synchronised acknowledge confirms the
// switch. A slow-space access or a force_ls demand while on the high-speed
// clock drops the request again, with the same stall-until-acknowledge rule.
//
// Build option:
//   CLKSW_TIMEOUT_EN  when defined, a switch whose acknowledge does not arrive
//                     within TIMEOUT_CYCLES cycles raises the sticky
//                     timeout_err flag (and an up-switch is abandoned). When
//                     undefined, switches wait indefinitely and timeout_err
//                     is tied low.
//
// Parameters:
//   SYNC_STAGES     flops in the hsclk_selected synchroniser (>= 2)
//   TIMEOUT_CYCLES  acknowledge wait limit in cycles (>= 2, timeout build only)
//
// Ports:
//   clk_in          block clock, rising edge
//   rst             synchronous active-high reset
//   access_valid    CPU presents an access this cycle
//   access_fast     access targets high-speed space (qualified by access_valid)
//   force_ls        demand to run on the low-speed clock
//   hsclk_selected  acknowledge from the clock controller (asynchronous)
//   hsclk_sel       registered request, 1 = high-speed clock
//   cpu_rdy         combinational, 0 stalls the current access
//   switch_busy     registered, 1 while a switch is in flight
//   timeout_err     registered sticky acknowledge-timeout flag
//   switch_count    registered count of completed switches, saturates at 255

module clksw_req #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       access_valid,
  input  logic       access_fast,
  input  logic       force_ls,
  input  logic       hsclk_selected,
  output logic       hsclk_sel,
  output logic       cpu_rdy,
  output logic       switch_busy,
  output logic       timeout_err,
  output logic [7:0] switch_count
);

  typedef enum logic [1:0] {
    ST_LS    = 2'd0,
    ST_TO_HS = 2'd1,
    ST_HS    = 2'd2,
    ST_TO_LS = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;

  // trig: the current cycle starts a switch out of a stable state.
  // done: the current cycle completes a switch into a stable state.
  logic trig;
  logic done;
  logic to_hit;

  // Acknowledge synchroniser; only its last stage is visible to the FSM.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], hsclk_selected};
    end
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

`ifdef CLKSW_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt;
  logic            to_fire;

  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // The limit only matters when nothing else moves the FSM this cycle:
  // force_ls and a matching acknowledge both take priority.
  assign to_fire = to_hit &
                   (((state == ST_TO_HS) & !force_ls & !ack_s) |
                    ((state == ST_TO_LS) & ack_s));

  // Cleared on every state change (so it starts at 0 on entry to a
  // transitional state) and after a TO_LS timeout, which keeps waiting.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      to_cnt <= '0;
    end else if ((state_nxt != state) || to_fire) begin
      to_cnt <= '0;
    end else if ((state == ST_TO_HS) || (state == ST_TO_LS)) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (to_fire) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next state and CPU stall decision.
  always_comb begin
    state_nxt = state;
    trig      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_LS: begin
        // With force_ls set, fast accesses simply run at low speed.
        if (access_valid & access_fast & !force_ls) begin
          trig      = 1'b1;
          state_nxt = ST_TO_HS;
        end
      end
      ST_TO_HS: begin
        if (force_ls) begin
          state_nxt = ST_TO_LS;
        end else if (ack_s) begin
          done      = 1'b1;
          state_nxt = ST_HS;
        end else if (to_hit) begin
          // Acknowledge never came: back the request out.
          state_nxt = ST_TO_LS;
        end
      end
      ST_HS: begin
        if (force_ls | (access_valid & !access_fast)) begin
          trig      = 1'b1;
          state_nxt = ST_TO_LS;
        end
      end
      ST_TO_LS: begin
        if (!ack_s) begin
          done      = 1'b1;
          state_nxt = ST_LS;
        end
      end
      default: begin
        state_nxt = ST_LS;
      end
    endcase
  end

  // The triggering access stalls, stays stalled through the switch and is
  // retired in the first cycle of the target stable state, where the held
  // inputs no longer form a trigger. Reset keeps the CPU unstalled.
  always_comb begin
    cpu_rdy = 1'b1;
    if (!rst) begin
      if ((state == ST_TO_HS) || (state == ST_TO_LS) || trig) begin
        cpu_rdy = 1'b0;
      end
    end
  end

  // State register and registered outputs, decoded from the next state so
  // hsclk_sel and switch_busy always agree with the state they describe.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state        <= ST_LS;
      hsclk_sel    <= 1'b0;
      switch_busy  <= 1'b0;
      switch_count <= 8'd0;
    end else begin
      state        <= state_nxt;
      hsclk_sel    <= (state_nxt == ST_TO_HS) || (state_nxt == ST_HS);
      switch_busy  <= (state_nxt == ST_TO_HS) || (state_nxt == ST_TO_LS);
      if (done && (switch_count != 8'd255)) begin
        switch_count <= switch_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_clksw_req.sv
// Testbench for clksw_req: a directed vector table, hand-written corner
// sequences, a saturation run and a randomized run, all compared every cycle
// against a behavioural model that tracks the requested speed and the speed
// the clock controller is believed to be running at.

module tb_clksw_req;

  localparam int SYNC = 2;
  localparam int TMO  = 64;

  logic       clk_in         = 1'b0;
  logic       rst            = 1'b0;
  logic       access_valid   = 1'b0;
  logic       access_fast    = 1'b0;
  logic       force_ls       = 1'b0;
  logic       hsclk_selected = 1'b0;
  logic       hsclk_sel;
  logic       cpu_rdy;
  logic       switch_busy;
  logic       timeout_err;
  logic [7:0] switch_count;

  clksw_req #(
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .access_valid   (access_valid),
    .access_fast    (access_fast),
    .force_ls       (force_ls),
    .hsclk_selected (hsclk_selected),
    .hsclk_sel      (hsclk_sel),
    .cpu_rdy        (cpu_rdy),
    .switch_busy    (switch_busy),
    .timeout_err    (timeout_err),
    .switch_count   (switch_count)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: m_req = speed requested, m_cur = speed the controller is taken to
  // be on. Equal means settled; different means a switch is pending. An
  // abandoned up-switch is modelled as "may be fast" (m_cur = 1, m_req = 0),
  // so it waits for the acknowledge to go low.
  logic       m_req;
  logic       m_cur;
  logic       m_err;
  logic       m_valid = 1'b0;
  logic [7:0] m_cnt;
  int         m_wait;
  logic       m_hist [SYNC];

  typedef struct {
    logic       av;
    logic       af;
    logic       fls;
    logic       ack;
    logic       rdy;
    logic       sel;
    logic       busy;
    logic [7:0] cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic av, af, fls, ack, rdy, sel, busy,
                              input logic [7:0] cnt);
    vec_t v;
    v.av = av; v.af = af; v.fls = fls; v.ack = ack;
    v.rdy = rdy; v.sel = sel; v.busy = busy; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic m_rdy(input logic r, av, af, fls);
    if (r) return 1'b1;
    if (m_req != m_cur) return 1'b0;
    if (m_cur) return !(fls | (av & !af));
    return !(av & af & !fls);
  endfunction

  task automatic model_step(input logic r, av, af, fls, ack);
    logic a_s;
    logic trig;
    a_s = m_hist[SYNC-1];
    if (r) begin
      m_req = 0; m_cur = 0; m_err = 0; m_cnt = 0; m_wait = 0; m_valid = 1;
      for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
      return;
    end
    if (m_req == m_cur) begin
      trig = m_cur ? (fls | (av & !af)) : (av & af & !fls);
      if (trig) begin
        m_req  = !m_cur;
        m_wait = 0;
      end
    end else if (m_req) begin
      if (fls) begin
        m_req = 0; m_cur = 1; m_wait = 0;
      end else if (a_s) begin
        m_cur = 1;
        if (m_cnt != 255) m_cnt = m_cnt + 1;
      end else begin
`ifdef CLKSW_TIMEOUT_EN
        if (m_wait == TMO - 1) begin
          m_req = 0; m_cur = 1; m_wait = 0; m_err = 1;
        end else begin
          m_wait++;
        end
`endif
      end
    end else begin
      if (!a_s) begin
        m_cur = 0;
        if (m_cnt != 255) m_cnt = m_cnt + 1;
      end else begin
`ifdef CLKSW_TIMEOUT_EN
        if (m_wait == TMO - 1) begin
          m_err = 1; m_wait = 0;
        end else begin
          m_wait++;
        end
`endif
      end
    end
    for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = ack;
  endtask

  task automatic check_model();
    chk("cpu_rdy", {7'd0, cpu_rdy}, {7'd0, m_rdy(rst, access_valid, access_fast, force_ls)});
    if (m_valid) begin
      chk("hsclk_sel", {7'd0, hsclk_sel}, {7'd0, m_req});
      chk("switch_busy", {7'd0, switch_busy}, {7'd0, m_req != m_cur});
      chk("timeout_err", {7'd0, timeout_err}, {7'd0, m_err});
      chk("switch_count", switch_count, m_cnt);
    end
  endtask

  task automatic drive(input logic r, av, af, fls, ack);
    @(negedge clk_in);
    rst = r; access_valid = av; access_fast = af; force_ls = fls; hsclk_selected = ack;
    #1;
  endtask

  task automatic fin();
    check_model();
    @(posedge clk_in);
    model_step(rst, access_valid, access_fast, force_ls, hsclk_selected);
  endtask

  task automatic cycle(input logic r, av, af, fls, ack);
    drive(r, av, af, fls, ack);
    fin();
  endtask

  initial begin
    logic rack;

    // Directed sequence starting from LS just after reset, SYNC = 2.
    //             av af fl ak   rdy sel busy cnt
    tbl[0]  = mk(1, 1, 0, 0,   0, 0, 0, 0);  // trigger LS -> TO_HS
    tbl[1]  = mk(1, 1, 0, 0,   0, 1, 1, 0);
    tbl[2]  = mk(1, 1, 0, 0,   0, 1, 1, 0);
    tbl[3]  = mk(1, 1, 0, 0,   0, 1, 1, 0);
    tbl[4]  = mk(1, 1, 0, 1,   0, 1, 1, 0);  // ack returns
    tbl[5]  = mk(1, 1, 0, 1,   0, 1, 1, 0);
    tbl[6]  = mk(1, 1, 0, 1,   0, 1, 1, 0);  // ack_s seen
    tbl[7]  = mk(1, 1, 0, 1,   1, 1, 0, 1);  // HS, access retired
    tbl[8]  = mk(1, 0, 0, 1,   0, 1, 0, 1);  // slow access triggers
    tbl[9]  = mk(1, 0, 0, 1,   0, 0, 1, 1);
    tbl[10] = mk(1, 0, 0, 0,   0, 0, 1, 1);  // ack dropped
    tbl[11] = mk(1, 0, 0, 0,   0, 0, 1, 1);
    tbl[12] = mk(1, 0, 0, 0,   0, 0, 1, 1);
    tbl[13] = mk(1, 0, 0, 0,   1, 0, 0, 2);  // LS reached
    tbl[14] = mk(1, 1, 1, 0,   1, 0, 0, 2);  // force_ls beats trigger
    tbl[15] = mk(0, 0, 0, 0,   1, 0, 0, 2);
    tbl[16] = mk(1, 1, 0, 0,   0, 0, 0, 2);  // trigger
    tbl[17] = mk(0, 0, 1, 0,   0, 1, 1, 2);  // force_ls in TO_HS
    tbl[18] = mk(0, 0, 0, 0,   0, 0, 1, 2);  // TO_LS, ack already low
    tbl[19] = mk(0, 0, 0, 0,   1, 0, 0, 3);

    // Reset and idle state.
    drive(1, 0, 0, 0, 0);
    chk("rst_rdy0", {7'd0, cpu_rdy}, 8'd1);
    fin();
    drive(1, 0, 0, 0, 0);
    chk("rst_rdy1", {7'd0, cpu_rdy}, 8'd1);
    chk("rst_sel", {7'd0, hsclk_sel}, 8'd0);
    chk("rst_cnt", switch_count, 8'd0);
    chk("rst_err", {7'd0, timeout_err}, 8'd0);
    fin();
    drive(0, 0, 0, 0, 0);
    chk("idle_rdy", {7'd0, cpu_rdy}, 8'd1);
    chk("idle_busy", {7'd0, switch_busy}, 8'd0);
    fin();

    for (int i = 0; i < NV; i++) begin
      drive(0, tbl[i].av, tbl[i].af, tbl[i].fls, tbl[i].ack);
      chk($sformatf("tbl%0d_rdy", i), {7'd0, cpu_rdy}, {7'd0, tbl[i].rdy});
      chk($sformatf("tbl%0d_sel", i), {7'd0, hsclk_sel}, {7'd0, tbl[i].sel});
      chk($sformatf("tbl%0d_busy", i), {7'd0, switch_busy}, {7'd0, tbl[i].busy});
      chk($sformatf("tbl%0d_cnt", i), switch_count, tbl[i].cnt);
      fin();
    end

    // HS left through force_ls.
    cycle(0, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    chk("hs_force_rdy", {7'd0, cpu_rdy}, 8'd0);
    fin();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);

    // Reset in the middle of an up-switch.
    cycle(0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    chk("mid_sel", {7'd0, hsclk_sel}, 8'd1);
    fin();
    drive(1, 1, 1, 0, 1);
    chk("mid_rst_rdy", {7'd0, cpu_rdy}, 8'd1);
    fin();
    drive(0, 0, 0, 0, 0);
    chk("mid_after_sel", {7'd0, hsclk_sel}, 8'd0);
    chk("mid_after_busy", {7'd0, switch_busy}, 8'd0);
    chk("mid_after_cnt", switch_count, 8'd0);
    fin();

    // Saturation: back-to-back switches with a prompt controller.
    for (int i = 0; i < 2000; i++) cycle(0, 1, !m_cur, 0, m_req);
    drive(0, 0, 0, 0, m_req);
    chk("sat_cnt", switch_count, 8'd255);
    fin();

    // Randomized traffic with a lagging controller.
    cycle(1, 0, 0, 0, 0);
    rack = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) rack = m_req;
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0), rack);
    end

    // Acknowledge never returned for an up-switch.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    for (int i = 0; i < TMO; i++) cycle(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
`ifdef CLKSW_TIMEOUT_EN
    chk("to_err", {7'd0, timeout_err}, 8'd1);
    chk("to_sel", {7'd0, hsclk_sel}, 8'd0);
    chk("to_busy", {7'd0, switch_busy}, 8'd1);
`else
    chk("to_err", {7'd0, timeout_err}, 8'd0);
    chk("to_sel", {7'd0, hsclk_sel}, 8'd1);
    chk("to_busy", {7'd0, switch_busy}, 8'd1);
`endif
    fin();
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
`ifdef CLKSW_TIMEOUT_EN
    chk("to_sticky", {7'd0, timeout_err}, 8'd1);
`else
    chk("to_wait_busy", {7'd0, switch_busy}, 8'd1);
`endif
    fin();
    cycle(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("to_rst_err", {7'd0, timeout_err}, 8'd0);
    fin();

    // Acknowledge stuck high during a down-switch.
    cycle(0, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
    for (int i = 0; i < TMO + 10; i++) cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
